// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: vector addresses, fetch FSM states
// and the next-PC source encoding.
package mips_pkg;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] INT_VECTOR = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } fetch_state_t;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_JUMP,
        SRC_JR,
        SRC_BRANCH,
        SRC_IRQ,
        SRC_EXC
    } redirect_src_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_next_pc_sel.sv
// Next-PC priority mux: exception > irq > branch > jr > jump > pc+4.
// Produces the word-aligned redirect target and a redirect flag.
module if_next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        exception,
    input  logic        irq,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] seq_pc
);

    redirect_src_t src;
    logic [31:0]   target;

    always_comb begin
        src = SRC_SEQ;
        if (exception)         src = SRC_EXC;
        else if (irq)          src = SRC_IRQ;
        else if (branch_taken) src = SRC_BRANCH;
        else if (jr)           src = SRC_JR;
        else if (jump)         src = SRC_JUMP;
    end

    always_comb begin
        target = seq_pc;
        unique case (src)
            SRC_EXC:    target = EXC_VECTOR;
            SRC_IRQ:    target = INT_VECTOR;
            SRC_BRANCH: target = branch_target;
            SRC_JR:     target = jr_target;
            SRC_JUMP:   target = jump_target;
            default:    target = seq_pc;
        endcase
    end

    assign seq_pc      = pc + 32'd4;
    assign redirect    = (src != SRC_SEQ);
    assign redirect_pc = word_align(target);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake,
// stall hold buffer and redirect/flush handling feeding the IF/ID register.
module if_fetch_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_stall,
    input  logic        exception,
    input  logic        irq,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_Instruction,
    output logic        IF_ID_Wr,
    output logic        if_clear_n
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  drop_addr;
    logic [31:0]  hold_buf;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic [31:0]  seq_pc;

    if_next_pc_sel u_next_pc_sel (
        .pc            (pc),
        .exception     (exception),
        .irq           (irq),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .seq_pc        (seq_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            hold_buf  <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            hold_buf <= '0;
            // An unanswered request keeps its old address in drop_addr until
            // the response arrives, so the PC is free to take the new target.
            unique case (state)
                FETCH: begin
                    if (!imem_ready) begin
                        state     <= DROP;
                        drop_addr <= pc;
                    end else begin
                        state <= FETCH;
                    end
                end
                DROP:    if (imem_ready) state <= FETCH;
                HOLD:    state <= FETCH;
                default: state <= FETCH;
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (pc_stall) begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                        end else begin
                            pc <= seq_pc;
                        end
                    end
                end
                HOLD: begin
                    if (!pc_stall) begin
                        pc    <= seq_pc;
                        state <= FETCH;
                    end
                end
                DROP:    if (imem_ready) state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs are decoded combinationally so a zero-wait response is written
    // to IF/ID in the same cycle as its request.
    always_comb begin
        imem_req       = 1'b0;
        imem_addr      = pc;
        IF_ID_Wr       = 1'b0;
        IF_Instruction = '0;
        if (!reset) begin
            unique case (state)
                FETCH: begin
                    imem_req       = 1'b1;
                    IF_Instruction = imem_rdata;
                    IF_ID_Wr       = imem_ready && !pc_stall && !redirect;
                end
                HOLD: begin
                    IF_Instruction = hold_buf;
                    IF_ID_Wr       = !pc_stall && !redirect;
                end
                DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = drop_addr;
                end
                default: ;
            endcase
        end
    end

    assign IF_PC      = reset ? RESET_PC : pc;
    assign if_clear_n = !(reset || redirect);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed + randomized bench for if_fetch_unit against a behavioural model.
module tb_if_fetch_unit;

    localparam logic [31:0] T_RESET = 32'h8000_0000;
    localparam logic [31:0] T_INT   = 32'h8000_0004;
    localparam logic [31:0] T_EXC   = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset, pc_stall, exception, irq, branch_taken, jr, jump;
    logic [31:0] branch_target, jr_target, jump_target;
    logic        imem_req, imem_ready, IF_ID_Wr, if_clear_n;
    logic [31:0] imem_addr, imem_rdata, IF_PC, IF_Instruction;

    int total = 0;
    int bad   = 0;

    // model: pc, an abandoned request awaiting its response, a held word
    logic [31:0] m_pc = T_RESET, m_drop_addr = '0, m_buf = '0;
    bit          m_drop = 1'b0, m_hold = 1'b0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc_stall       (pc_stall),
        .exception      (exception),
        .irq            (irq),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jr             (jr),
        .jr_target      (jr_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .IF_PC          (IF_PC),
        .IF_Instruction (IF_Instruction),
        .IF_ID_Wr       (IF_ID_Wr),
        .if_clear_n     (if_clear_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] redirect_target();
        logic [31:0] t;
        if (exception)         t = T_EXC;
        else if (irq)          t = T_INT;
        else if (branch_taken) t = branch_target;
        else if (jr)           t = jr_target;
        else                   t = jump_target;
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic idle_inputs();
        reset = 1'b0; pc_stall = 1'b0; imem_ready = 1'b1;
        exception = 1'b0; irq = 1'b0; branch_taken = 1'b0; jr = 1'b0; jump = 1'b0;
        branch_target = '0; jr_target = '0; jump_target = '0;
    endtask

    task automatic settle();
        imem_rdata = mem_word(m_drop ? m_drop_addr : m_pc);
        #1;
    endtask

    // Compare all outputs against the model, then advance the model across the edge.
    task automatic cycle();
        bit          redir, exp_req, exp_wr;
        logic [31:0] exp_instr;
        settle();
        redir     = exception || irq || branch_taken || jr || jump;
        exp_req   = !reset && !m_hold;
        exp_wr    = !reset && !redir && !pc_stall && (m_hold || (!m_drop && imem_ready));
        exp_instr = reset ? 32'h0 : m_hold ? m_buf : (!m_drop ? imem_rdata : 32'h0);
        check("req", {31'h0, imem_req}, {31'h0, exp_req});
        if (exp_req) check("addr", imem_addr, m_drop ? m_drop_addr : m_pc);
        check("wr", {31'h0, IF_ID_Wr}, {31'h0, exp_wr});
        check("clear_n", {31'h0, if_clear_n}, {31'h0, !(reset || redir)});
        check("instr", IF_Instruction, exp_instr);
        check("if_pc", IF_PC, reset ? T_RESET : m_pc);
        @(posedge clk);
        if (reset) begin
            m_pc = T_RESET; m_drop = 1'b0; m_hold = 1'b0;
        end else if (redir) begin
            if (m_drop) m_drop = !imem_ready;
            else if (!m_hold && !imem_ready) begin
                m_drop = 1'b1; m_drop_addr = m_pc;
            end
            m_hold = 1'b0;
            m_pc = redirect_target();
        end else if (m_drop) begin
            if (imem_ready) m_drop = 1'b0;
        end else if (m_hold) begin
            if (!pc_stall) begin m_hold = 1'b0; m_pc = m_pc + 32'd4; end
        end else if (imem_ready) begin
            if (pc_stall) begin m_hold = 1'b1; m_buf = imem_rdata; end
            else m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        imem_rdata = '0;
        @(negedge clk);

        reset = 1'b1;
        settle();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_clr", {31'h0, if_clear_n}, 32'h0);
        check("rst_pc", IF_PC, T_RESET);
        cycle(); cycle();

        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("seq_addr", imem_addr, T_RESET + 32'(4 * i));
            check("seq_wr", {31'h0, IF_ID_Wr}, 32'h1);
            cycle();
        end

        pc_stall = 1'b1;
        settle();
        check("stall_addr", imem_addr, 32'h8000_0010);
        check("stall_wr", {31'h0, IF_ID_Wr}, 32'h0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hold_instr", IF_Instruction, mem_word(32'h8000_0010));
            check("hold_wr", {31'h0, IF_ID_Wr}, 32'h0);
            check("hold_req", {31'h0, imem_req}, 32'h0);
            cycle();
        end
        pc_stall = 1'b0;
        settle();
        check("release_wr", {31'h0, IF_ID_Wr}, 32'h1);
        check("release_instr", IF_Instruction, mem_word(32'h8000_0010));
        cycle();
        settle();
        check("after_hold_addr", imem_addr, 32'h8000_0014);
        cycle(); cycle(); cycle();

        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h8000_0100;
        settle();
        check("br_addr", imem_addr, 32'h8000_0020);
        check("br_clr", {31'h0, if_clear_n}, 32'h0);
        cycle();
        branch_taken = 1'b0;
        settle();
        check("drop_addr", imem_addr, 32'h8000_0020);
        check("drop_clr", {31'h0, if_clear_n}, 32'h1);
        cycle();
        imem_ready = 1'b1;
        settle();
        check("drop_wr", {31'h0, IF_ID_Wr}, 32'h0);
        cycle();
        settle();
        check("br_target_addr", imem_addr, 32'h8000_0100);
        cycle();

        exception = 1'b1; irq = 1'b1; jump = 1'b1; jump_target = 32'h1234_5678;
        cycle();
        idle_inputs();
        settle();
        check("exc_prio_addr", imem_addr, T_EXC);
        cycle();

        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        cycle();
        jump = 1'b0;
        settle();
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        cycle();
        settle();
        check("wrap_addr", imem_addr, 32'h0000_0000);
        cycle();
        jump = 1'b1; jump_target = 32'h0000_0043;
        cycle();
        jump = 1'b0;
        settle();
        check("align_addr", imem_addr, 32'h0000_0040);
        cycle();

        imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h0000_0200;
        cycle();
        jump = 1'b0; reset = 1'b1;
        settle();
        check("drop_rst_req", {31'h0, imem_req}, 32'h0);
        check("drop_rst_instr", IF_Instruction, 32'h0);
        cycle();
        reset = 1'b0; imem_ready = 1'b1;
        settle();
        check("post_rst_addr", imem_addr, T_RESET);
        check("post_rst_req", {31'h0, imem_req}, 32'h1);
        cycle();

        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom % 150) == 0;
            pc_stall      = ($urandom % 4) == 0;
            imem_ready    = ($urandom % 3) != 0;
            exception     = ($urandom % 40) == 0;
            irq           = ($urandom % 30) == 0;
            branch_taken  = ($urandom % 12) == 0;
            jr            = ($urandom % 15) == 0;
            jump          = ($urandom % 15) == 0;
            branch_target = $urandom;
            jr_target     = $urandom;
            jump_target   = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
